// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline control path.
// Holds the RV32 opcode encodings, the ALU operation codes and the control
// bundle struct produced by ID decode and carried down the pipeline.
package pipe_ctrl_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_SD    = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_NOP   = 7'b0000000;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_RFUNC = 3'b010;
  localparam logic [2:0] ALU_OP_IFUNC = 3'b011;
  localparam logic [2:0] ALU_OP_PASSB = 3'b100;
  localparam logic [2:0] ALU_OP_LINK  = 3'b101;
  localparam logic [2:0] ALU_OP_PCADD = 3'b110;

  // Control bundle. rd is width-parameterised, so the top pairs it with this
  // struct in its own stage type rather than storing it here.
  typedef struct packed {
    logic       mr;
    logic       m2r;
    logic       mw;
    logic       rw;
    logic       br;
    logic       jp;
    logic       src;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // True for the four opcodes gated by ENABLE_UJ.
  function automatic logic is_uj_opcode(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder.
// Ports: opcode_i / rd_i   - instruction fields in ID
//        ctrl_o            - control bundle (rw suppressed for rd == x0)
//        rs1_used_o/rs2_used_o - source operands actually read by the instruction
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          ENABLE_UJ  = 1'b1
) (
  input  logic [6:0]            opcode_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output ctrl_t                 ctrl_o,
  output logic                  rs1_used_o,
  output logic                  rs2_used_o
);

  always_comb begin
    ctrl_o     = '0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    if (is_uj_opcode(opcode_i) && !ENABLE_UJ) begin
      ctrl_o.illegal = 1'b1;
    end else begin
      case (opcode_i)
        OPC_R: begin
          ctrl_o.rw     = 1'b1;
          ctrl_o.alu_op = ALU_OP_RFUNC;
          rs1_used_o    = 1'b1;
          rs2_used_o    = 1'b1;
        end
        OPC_LD: begin
          ctrl_o.mr     = 1'b1;
          ctrl_o.m2r    = 1'b1;
          ctrl_o.rw     = 1'b1;
          ctrl_o.src    = 1'b1;
          ctrl_o.alu_op = ALU_OP_ADD;
          rs1_used_o    = 1'b1;
        end
        OPC_SD: begin
          ctrl_o.mw     = 1'b1;
          ctrl_o.src    = 1'b1;
          ctrl_o.alu_op = ALU_OP_ADD;
          rs1_used_o    = 1'b1;
          rs2_used_o    = 1'b1;
        end
        OPC_BEQ: begin
          ctrl_o.br     = 1'b1;
          ctrl_o.alu_op = ALU_OP_SUB;
          rs1_used_o    = 1'b1;
          rs2_used_o    = 1'b1;
        end
        OPC_I: begin
          ctrl_o.rw     = 1'b1;
          ctrl_o.src    = 1'b1;
          ctrl_o.alu_op = ALU_OP_IFUNC;
          rs1_used_o    = 1'b1;
        end
        OPC_JAL: begin
          ctrl_o.rw     = 1'b1;
          ctrl_o.jp     = 1'b1;
          ctrl_o.alu_op = ALU_OP_LINK;
        end
        OPC_JALR: begin
          ctrl_o.rw     = 1'b1;
          ctrl_o.jp     = 1'b1;
          ctrl_o.src    = 1'b1;
          ctrl_o.alu_op = ALU_OP_LINK;
          rs1_used_o    = 1'b1;
        end
        OPC_LUI: begin
          ctrl_o.rw     = 1'b1;
          ctrl_o.src    = 1'b1;
          ctrl_o.alu_op = ALU_OP_PASSB;
        end
        OPC_AUIPC: begin
          ctrl_o.rw     = 1'b1;
          ctrl_o.src    = 1'b1;
          ctrl_o.alu_op = ALU_OP_PCADD;
        end
        OPC_NOP: ;
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
    // Writes to x0 are architecturally discarded; drop them here so no later
    // stage or forwarding path has to special-case x0.
    if (rd_i == '0) ctrl_o.rw = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control path of the 5-stage core: decodes ID, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, and generates stall/flush controls.
// Inputs : clk, reset (sync, active high), id_opcode/id_rs1/id_rs2/id_rd,
//          ext_stall (global freeze), ex_redirect (taken branch/jump in EX).
// Outputs: pc_write, ifid_write, ifid_flush (combinational),
//          ex_* / mem_* / wb_* stage controls and wb_rd (registered).
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          ENABLE_UJ  = 1'b1,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ext_stall,
  input  logic                  ex_redirect,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_illegal,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  // Later stages only keep the fields they still consume.
  typedef struct packed {
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic                  mr;
    logic                  mw;
    logic                  rw;
    logic                  m2r;
    logic [REG_ADDR_W-1:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic                  rw;
    logic                  m2r;
    logic [REG_ADDR_W-1:0] rd;
  } wb_stage_t;

  ctrl_t      dec_ctrl;
  logic       rs1_used, rs2_used;
  logic       hazard;
  ex_stage_t  id_ex_d, id_ex_q;
  mem_stage_t ex_mem_d, ex_mem_q;
  wb_stage_t  mem_wb_d, mem_wb_q;

  ctrl_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .ENABLE_UJ  (ENABLE_UJ)
  ) u_decode (
    .opcode_i   (id_opcode),
    .rd_i       (id_rd),
    .ctrl_o     (dec_ctrl),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  always_comb begin
    hazard = HAZARD_EN && id_ex_q.ctrl.mr && (id_ex_q.rd != '0) &&
             ((rs1_used && (id_ex_q.rd == id_rs1)) || (rs2_used && (id_ex_q.rd == id_rs2)));

    id_ex_d    = id_ex_q;
    ex_mem_d   = ex_mem_q;
    mem_wb_d   = mem_wb_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;

    if (reset) begin
      // Registers clear in the flop process; front-end controls stay enabled.
    end else if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      ex_mem_d = '{mr:  id_ex_q.ctrl.mr,  mw: id_ex_q.ctrl.mw, rw: id_ex_q.ctrl.rw,
                   m2r: id_ex_q.ctrl.m2r, rd: id_ex_q.rd};
      mem_wb_d = '{rw: ex_mem_q.rw, m2r: ex_mem_q.m2r, rd: ex_mem_q.rd};
      if (ex_redirect) begin
        // The ID instruction is on the wrong path, so a pending hazard is moot.
        id_ex_d    = '0;
        ifid_flush = 1'b1;
      end else if (hazard) begin
        id_ex_d    = '0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else begin
        id_ex_d = '{ctrl: dec_ctrl, rd: id_rd};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign ex_alu_src    = id_ex_q.ctrl.src;
  assign ex_branch     = id_ex_q.ctrl.br;
  assign ex_jump       = id_ex_q.ctrl.jp;
  assign ex_alu_op     = id_ex_q.ctrl.alu_op;
  assign ex_illegal    = id_ex_q.ctrl.illegal;
  assign mem_read      = ex_mem_q.mr;
  assign mem_write     = ex_mem_q.mw;
  assign wb_reg_write  = mem_wb_q.rw;
  assign wb_mem_to_reg = mem_wb_q.m2r;
  assign wb_rd         = mem_wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (UJ decode on / off) driven with the
// same stream and compared against a stage-array reference model.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ext_stall, ex_redirect;

  logic       pc_write [2];
  logic       ifid_write [2];
  logic       ifid_flush [2];
  logic       ex_alu_src [2];
  logic       ex_branch [2];
  logic       ex_jump [2];
  logic [2:0] ex_alu_op [2];
  logic       ex_illegal [2];
  logic       mem_read [2];
  logic       mem_write [2];
  logic       wb_reg_write [2];
  logic       wb_mem_to_reg [2];
  logic [4:0] wb_rd [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_ctrl_unit #(
      .REG_ADDR_W (5),
      .ENABLE_UJ  (g == 0),
      .HAZARD_EN  (1'b1)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .id_opcode     (id_opcode),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .ext_stall     (ext_stall),
      .ex_redirect   (ex_redirect),
      .pc_write      (pc_write[g]),
      .ifid_write    (ifid_write[g]),
      .ifid_flush    (ifid_flush[g]),
      .ex_alu_src    (ex_alu_src[g]),
      .ex_branch     (ex_branch[g]),
      .ex_jump       (ex_jump[g]),
      .ex_alu_op     (ex_alu_op[g]),
      .ex_illegal    (ex_illegal[g]),
      .mem_read      (mem_read[g]),
      .mem_write     (mem_write[g]),
      .wb_reg_write  (wb_reg_write[g]),
      .wb_mem_to_reg (wb_mem_to_reg[g]),
      .wb_rd         (wb_rd[g])
    );
  end

  // Reference model: one instruction record per stage, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       mr, m2r, mw, rw, br, jp, src;
    logic [2:0] alu_op;
    logic       illegal;
    logic [4:0] rd;
  } ins_t;

  ins_t pipe_m [2][3];
  int   errors = 0;
  int   checks = 0;
  bit   exp_ifid_write0, exp_flush0;

  function automatic void ref_decode(input logic [6:0] op, input logic [4:0] rd, input bit uj,
                                     output ins_t e, output bit u1, output bit u2);
    e  = '0;
    u1 = 1'b0;
    u2 = 1'b0;
    case (op)
      7'b0110011: begin e.rw = 1; e.alu_op = 3'b010; u1 = 1; u2 = 1; end
      7'b0000011: begin e.mr = 1; e.m2r = 1; e.rw = 1; e.src = 1; u1 = 1; end
      7'b0100011: begin e.mw = 1; e.src = 1; u1 = 1; u2 = 1; end
      7'b1100011: begin e.br = 1; e.alu_op = 3'b001; u1 = 1; u2 = 1; end
      7'b0010011: begin e.rw = 1; e.src = 1; e.alu_op = 3'b011; u1 = 1; end
      7'b1101111: if (uj) begin e.rw = 1; e.jp = 1; e.alu_op = 3'b101; end else e.illegal = 1;
      7'b1100111: if (uj) begin e.rw = 1; e.jp = 1; e.src = 1; e.alu_op = 3'b101; u1 = 1; end
                  else e.illegal = 1;
      7'b0110111: if (uj) begin e.rw = 1; e.src = 1; e.alu_op = 3'b100; end else e.illegal = 1;
      7'b0010111: if (uj) begin e.rw = 1; e.src = 1; e.alu_op = 3'b110; end else e.illegal = 1;
      7'b0000000: ;
      default:    e.illegal = 1;
    endcase
    if (rd == 5'd0) e.rw = 1'b0;
    e.rd = rd;
  endfunction

  function automatic bit ref_hazard(input int k);
    ins_t e;
    bit   u1, u2;
    ref_decode(id_opcode, id_rd, k == 0, e, u1, u2);
    return pipe_m[k][0].mr && (pipe_m[k][0].rd != 5'd0) &&
           ((u1 && pipe_m[k][0].rd == id_rs1) || (u2 && pipe_m[k][0].rd == id_rs2));
  endfunction

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit   haz, e_pc, e_ifw, e_fl;
      ins_t ex, mm, wb;
      haz  = ref_hazard(k);
      ex   = pipe_m[k][0];
      mm   = pipe_m[k][1];
      wb   = pipe_m[k][2];
      e_fl = !reset && !ext_stall && ex_redirect;
      e_pc = reset || (!ext_stall && (ex_redirect || !haz));
      e_ifw = e_pc;
      if (k == 0) begin
        exp_ifid_write0 = e_ifw;
        exp_flush0      = e_fl;
      end
      chk("pc_write", k, 8'(pc_write[k]), 8'(e_pc));
      chk("ifid_write", k, 8'(ifid_write[k]), 8'(e_ifw));
      chk("ifid_flush", k, 8'(ifid_flush[k]), 8'(e_fl));
      chk("ex_alu_src", k, 8'(ex_alu_src[k]), 8'(ex.src));
      chk("ex_branch", k, 8'(ex_branch[k]), 8'(ex.br));
      chk("ex_jump", k, 8'(ex_jump[k]), 8'(ex.jp));
      chk("ex_alu_op", k, 8'(ex_alu_op[k]), 8'(ex.alu_op));
      chk("ex_illegal", k, 8'(ex_illegal[k]), 8'(ex.illegal));
      chk("mem_read", k, 8'(mem_read[k]), 8'(mm.mr));
      chk("mem_write", k, 8'(mem_write[k]), 8'(mm.mw));
      chk("wb_reg_write", k, 8'(wb_reg_write[k]), 8'(wb.rw));
      chk("wb_mem_to_reg", k, 8'(wb_mem_to_reg[k]), 8'(wb.m2r));
      chk("wb_rd", k, 8'(wb_rd[k]), 8'(wb.rd));
    end
  endtask

  // Model clock edge: shift the stage array according to the priority rules.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      ins_t d;
      bit   u1, u2, haz;
      ref_decode(id_opcode, id_rd, k == 0, d, u1, u2);
      haz = ref_hazard(k);
      if (reset) begin
        for (int s = 0; s < 3; s++) pipe_m[k][s] = '0;
      end else if (!ext_stall) begin
        pipe_m[k][2] = pipe_m[k][1];
        pipe_m[k][1] = pipe_m[k][0];
        pipe_m[k][0] = (ex_redirect || haz) ? '0 : d;
      end
    end
  endtask

  task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic st, input logic rdir, input logic rs);
    @(negedge clk);
    id_opcode   = op;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    ext_stall   = st;
    ex_redirect = rdir;
    reset       = rs;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
  endtask

  logic [6:0] ops [12] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17,
                           7'h00, 7'h7F, 7'h0B};

  initial begin
    logic [6:0] op;
    logic [4:0] r1, r2, rd;
    for (int k = 0; k < 2; k++) for (int s = 0; s < 3; s++) pipe_m[k][s] = '0;
    reset = 1'b1; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    ext_stall = 1'b0; ex_redirect = 1'b0;

    // Reset with an R-type in ID, then let it flow to WB.
    step(7'h33, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    step(7'h33, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    step(7'h33, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // LD x5 ; ADD x6,x5,x1 stalls once, ADD re-presented.
    step(7'h03, 5'd2, 5'd0, 5'd5, 0, 0, 0);
    step(7'h33, 5'd5, 5'd1, 5'd6, 0, 0, 0);
    step(7'h33, 5'd5, 5'd1, 5'd6, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // LD x0 then ADD using x0; LD x5 then LUI x7: no stall.
    step(7'h03, 5'd2, 5'd0, 5'd0, 0, 0, 0);
    step(7'h33, 5'd0, 5'd0, 5'd6, 0, 0, 0);
    step(7'h03, 5'd2, 5'd0, 5'd5, 0, 0, 0);
    step(7'h37, 5'd5, 5'd5, 5'd7, 0, 0, 0);

    // Redirect concurrent with a load-use hazard.
    step(7'h03, 5'd2, 5'd0, 5'd5, 0, 0, 0);
    step(7'h33, 5'd5, 5'd5, 5'd6, 0, 1, 0);
    step(7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Three-cycle freeze mid-stream.
    step(7'h13, 5'd1, 5'd0, 5'd8, 0, 0, 0);
    step(7'h23, 5'd1, 5'd2, 5'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(7'h63, 5'd3, 5'd4, 5'd0, 1, 0, 0);
    step(7'h63, 5'd3, 5'd4, 5'd0, 0, 0, 0);

    // Illegal opcode, and JAL (illegal only in the ENABLE_UJ=0 instance).
    step(7'h7F, 5'd1, 5'd2, 5'd9, 0, 0, 0);
    step(7'h6F, 5'd0, 5'd0, 5'd1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Randomised stream; ID holds on stall and becomes a NOP after a flush.
    op = 7'h00; r1 = '0; r2 = '0; rd = '0;
    for (int n = 0; n < 1500; n++) begin
      logic st, rdir, rs;
      st   = ($urandom_range(0, 9) == 0);
      rdir = ($urandom_range(0, 7) == 0);
      rs   = ($urandom_range(0, 99) == 0);
      step(op, r1, r2, rd, st, rdir, rs);
      if (exp_flush0) begin
        op = 7'h00; r1 = '0; r2 = '0; rd = '0;
      end else if (exp_ifid_write0) begin
        op = ops[$urandom_range(0, 11)];
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
